// File: rtl/div_seq_pkg.sv
// Shared constants, op-decode types and helpers for the RV64M divide sequencer.
package div_seq_pkg;

  localparam int DIV_XLEN = 64;
  localparam int WORD_W   = 32;
  localparam int COUNT_W  = $clog2(DIV_XLEN) + 1;

  // Divide-class funct3 encodings (OP / OP-32 with the M-extension funct7).
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef struct packed {
    logic is_signed;
    logic is_rem;
    logic is_word;
  } div_op_t;

  function automatic div_op_t div_decode(input logic [2:0] funct3, input logic op32);
    div_op_t op;
    op = '0;
    unique case (funct3)
      F3_DIV:  begin op.is_signed = 1'b1; op.is_rem = 1'b0; end
      F3_DIVU: begin op.is_signed = 1'b0; op.is_rem = 1'b0; end
      F3_REM:  begin op.is_signed = 1'b1; op.is_rem = 1'b1; end
      F3_REMU: begin op.is_signed = 1'b0; op.is_rem = 1'b1; end
      default: op = '0;
    endcase
    op.is_word = op32;
    return op;
  endfunction

  // Widen a 32-bit operand to XLEN, sign- or zero-extending.
  function automatic logic [DIV_XLEN-1:0] word_ext(input logic [WORD_W-1:0] x, input logic sgn);
    return {{(DIV_XLEN-WORD_W){sgn & x[WORD_W-1]}}, x};
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step
  import div_seq_pkg::*;
#(
  parameter int W = DIV_XLEN
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvsr,
  output logic [W-1:0] rem_nxt,
  output logic [W-1:0] quo_nxt
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // The shifted partial remainder needs one extra bit; a clear top bit of the
  // difference means the divisor fits and the quotient bit is 1.
  always_comb begin
    shifted = {rem, quo[W-1]};
    trial   = shifted - {1'b0, dvsr};
    if (!trial[W]) begin
      rem_nxt = trial[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle RV64M divide/remainder sequencer: stalls EX while a restoring
// divider iterates, then presents the sign-corrected result for one or more cycles.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            stall,
  input  logic            start,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic            is_word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [XLEN-1:0]    DWORD_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]    WORD_MIN  = {{(XLEN-WORD_W+1){1'b1}}, {(WORD_W-1){1'b0}}};
  localparam logic [COUNT_W-1:0] CNT_DWORD = COUNT_W'(XLEN);
  localparam logic [COUNT_W-1:0] CNT_WORD  = COUNT_W'(WORD_W);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q;
  logic [XLEN-1:0]    rem_q, quo_q, dvsr_q;
  logic               neg_quo_q, neg_rem_q, is_rem_q, is_word_q;

  div_op_t            op_in;
  logic [XLEN-1:0]    a_ext, b_ext, mag_a, mag_b, quo_load;
  logic               sign_a, sign_b, div_zero, div_ovf, accept;
  logic [XLEN-1:0]    step_rem, step_quo;
  logic [XLEN-1:0]    sel_val, fixed_val, final_val;
  logic               sel_neg;

  assign op_in  = '{is_signed: is_signed, is_rem: is_rem, is_word: is_word};
  assign accept = start & ~clear & (state_q == S_IDLE);

  // Operand conditioning for the issuing cycle. *W magnitudes sit in the low
  // half, so the quotient register is loaded MSB-aligned for a 32-step run.
  always_comb begin
    a_ext    = op_in.is_word ? word_ext(dividend[WORD_W-1:0], op_in.is_signed) : dividend;
    b_ext    = op_in.is_word ? word_ext(divisor[WORD_W-1:0], op_in.is_signed) : divisor;
    sign_a   = op_in.is_signed & a_ext[XLEN-1];
    sign_b   = op_in.is_signed & b_ext[XLEN-1];
    mag_a    = sign_a ? -a_ext : a_ext;
    mag_b    = sign_b ? -b_ext : b_ext;
    quo_load = op_in.is_word ? {mag_a[WORD_W-1:0], {(XLEN-WORD_W){1'b0}}} : mag_a;
    div_zero = (b_ext == '0);
    div_ovf  = op_in.is_signed & (b_ext == '1)
             & (a_ext == (op_in.is_word ? WORD_MIN : DWORD_MIN));
  end

  div_step #(.W(XLEN)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvsr    (dvsr_q),
    .rem_nxt (step_rem),
    .quo_nxt (step_quo)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the datapath registers are reset as well; they are a handful of
  // flops, not a memory, and a defined post-reset value keeps bring-up simple.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      is_word_q <= 1'b0;
    end else if (accept) begin
      is_rem_q  <= op_in.is_rem;
      is_word_q <= op_in.is_word;
      dvsr_q    <= mag_b;
      if (div_zero) begin
        quo_q     <= '1;
        rem_q     <= a_ext;
        neg_quo_q <= 1'b0;
        neg_rem_q <= 1'b0;
        count_q   <= '0;
      end else if (div_ovf) begin
        quo_q     <= a_ext;
        rem_q     <= '0;
        neg_quo_q <= 1'b0;
        neg_rem_q <= 1'b0;
        count_q   <= '0;
      end else begin
        quo_q     <= quo_load;
        rem_q     <= '0;
        neg_quo_q <= sign_a ^ sign_b;
        neg_rem_q <= sign_a;
        count_q   <= op_in.is_word ? CNT_WORD : CNT_DWORD;
      end
    end else if (state_q == S_BUSY && !clear) begin
      rem_q   <= step_rem;
      quo_q   <= step_quo;
      count_q <= count_q - COUNT_W'(1);
    end
  end

  // NOTE: next state gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = (div_zero || div_ovf) ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (clear)                        state_d = S_IDLE;
        else if (count_q == COUNT_W'(1))  state_d = S_DONE;
      end
      S_DONE: if (clear || !stall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result registers are frozen in DONE, so the output is stable for as long
  // as the downstream stall holds it.
  always_comb begin
    sel_val   = is_rem_q ? rem_q : quo_q;
    sel_neg   = is_rem_q ? neg_rem_q : neg_quo_q;
    fixed_val = sel_neg ? -sel_val : sel_val;
    final_val = is_word_q ? word_ext(fixed_val[WORD_W-1:0], 1'b1) : fixed_val;
    result    = (state_q == S_DONE) ? final_val : '0;
  end

  // The issuing cycle itself must be held, hence combinational on start; reset
  // also drops the request so a held pipeline is released immediately.
  assign stall_req = rst_n & start & (state_q != S_DONE) & ~clear;
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: scoreboard of expected results/latencies, popped on done.
module tb_div_seq;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        stall;
  logic        start;
  logic        is_signed;
  logic        is_rem;
  logic        is_word;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        stall_req;
  logic        done;
  logic [63:0] result;

  typedef struct {
    string       tag;
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  div_seq #(.XLEN(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .stall     (stall),
    .start     (start),
    .is_signed (is_signed),
    .is_rem    (is_rem),
    .is_word   (is_word),
    .dividend  (dividend),
    .divisor   (divisor),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result using the simulator's own arithmetic.
  function automatic logic [63:0] ref_div(input bit sgn, input bit rem, input bit word,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] q, r;
    if (word) begin
      logic [31:0] a32, b32, q32, r32;
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF;
        r32 = a32;
      end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32;
        r32 = 32'd0;
      end else if (sgn) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q = '1;
        r = a;
      end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a;
        r = 64'd0;
      end else if (sgn) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
    return rem ? r : q;
  endfunction

  function automatic int ref_lat(input bit sgn, input bit word,
                                 input logic [63:0] a, input logic [63:0] b);
    if (word) begin
      if (b[31:0] == 32'd0) return 2;
      if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 2;
      return 34;
    end
    if (b == 64'd0) return 2;
    if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return 2;
    return 66;
  endfunction

  // Called just after a falling edge; returns just after a falling edge with
  // start dropped, so another call issues back-to-back.
  task automatic run_op(input string tag, input bit sgn, input bit rem, input bit word,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat, input int hold);
    exp_t e;
    int   cycles;
    int   stalled;
    bit   got;
    sb.push_back('{tag, exp_res, exp_lat});
    start = 1'b1; is_signed = sgn; is_rem = rem; is_word = word;
    dividend = a; divisor = b; clear = 1'b0; stall = 1'b0;
    cycles = 0; stalled = 0; got = 1'b0;
    #1;
    while (!got && cycles < 200) begin
      if (done) got = 1'b1;
      else begin
        if (stall_req) stalled++;
        cycles++;
        @(negedge clk);
        #1;
      end
    end
    e = sb.pop_front();
    check({e.tag, "_done"}, 64'(got), 64'd1);
    if (got) begin
      check({e.tag, "_result"}, result, e.res);
      check({e.tag, "_latency"}, 64'(cycles + 1), 64'(e.lat));
      check({e.tag, "_stall_cycles"}, 64'(stalled), 64'(e.lat - 1));
      check({e.tag, "_stall_req_in_done"}, 64'(stall_req), 64'd0);
      for (int h = 0; h < hold; h++) begin
        stall = 1'b1;
        @(negedge clk);
        #1;
        check({e.tag, "_held_done"}, 64'(done), 64'd1);
        check({e.tag, "_held_result"}, result, e.res);
      end
      stall = 1'b0;
    end else begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    check({e.tag, "_done_exit"}, 64'(done), 64'd0);
    check({e.tag, "_result_zero_after"}, result, 64'd0);
  endtask

  initial begin
    bit          r_sgn, r_rem, r_word;
    logic [63:0] r_a, r_b;

    rst_n = 1'b0; clear = 1'b0; stall = 1'b0; start = 1'b1;
    is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
    dividend = '0; divisor = '0;
    #3;
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_stall_req", 64'(stall_req), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    #1;
    check("idle_done", 64'(done), 64'd0);

    run_op("div_100_7",  1, 0, 0, 64'd100, 64'd7, 64'hE, 66, 0);
    run_op("rem_100_7",  1, 1, 0, 64'd100, 64'd7, 64'd2, 66, 0);
    run_op("rem_m100_7", 1, 1, 0, -64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
    run_op("div_m100_7", 1, 0, 0, -64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 66, 0);
    run_op("divu_5_0",   0, 0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    run_op("remu_5_0",   0, 1, 0, 64'd5, 64'd0, 64'd5, 2, 0);
    run_op("div_ovf",    1, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 2, 0);
    run_op("divw_ovf",   1, 0, 1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 2, 0);
    run_op("divuw_max_1", 0, 0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1,
           64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
    run_op("remuw_0",    0, 1, 1, 64'h0000_0000_8000_0000, 64'd0,
           64'hFFFF_FFFF_8000_0000, 2, 0);

    // Flush in BUSY cycle 10, then an immediate new op.
    start = 1'b1; is_signed = 1'b1; is_rem = 1'b0; is_word = 1'b0;
    dividend = 64'd1000; divisor = 64'd3;
    repeat (10) @(negedge clk);
    #1;
    check("pre_clear_stall_req", 64'(stall_req), 64'd1);
    clear = 1'b1;
    #1;
    check("clear_stall_req", 64'(stall_req), 64'd0);
    check("clear_done", 64'(done), 64'd0);
    @(negedge clk);
    #1;
    check("after_clear_done", 64'(done), 64'd0);
    run_op("div_9_3_after_clear", 1, 0, 0, 64'd9, 64'd3, 64'd3, 66, 0);

    // Downstream stall holds DONE for 3 extra cycles.
    run_op("div_stall_hold", 1, 0, 0, 64'd100, 64'd7, 64'hE, 66, 3);

    // Back-to-back ops with no gap between DONE exit and the next issue.
    run_op("b2b_first",  0, 0, 0, 64'd77, 64'd7, 64'd11, 66, 0);
    run_op("b2b_second", 0, 1, 1, 64'd77, 64'd10, 64'd7, 34, 0);

    for (int i = 0; i < 4; i++) begin
      r_sgn  = 1'($urandom);
      r_rem  = 1'($urandom);
      r_word = 1'($urandom);
      r_a    = {$urandom, $urandom};
      r_b    = {$urandom, $urandom} >> $urandom_range(0, 60);
      run_op($sformatf("rand%0d", i), r_sgn, r_rem, r_word, r_a, r_b,
             ref_div(r_sgn, r_rem, r_word, r_a, r_b), ref_lat(r_sgn, r_word, r_a, r_b), 0);
    end

    // Reset in the middle of BUSY with start still high.
    start = 1'b1; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
    dividend = 64'd12345; divisor = 64'd17;
    repeat (20) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midbusy_reset_stall_req", 64'(stall_req), 64'd0);
    check("midbusy_reset_done", 64'(done), 64'd0);
    check("midbusy_reset_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    #1;
    run_op("after_reset", 0, 0, 0, 64'd12345, 64'd17, 64'd726, 66, 0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
